// File: rtl/pipe_snapshot_reader.sv
// pipe_snapshot_reader: captures one ID/EX pipeline snapshot and streams it out as a byte frame
// Frame layout: 0xA5 header, then 9 words (7 data words, fields word, ctrl word), least-significant
// byte first, optionally followed by an XOR checksum byte when SNAP_CHECKSUM_EN is defined.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_req               snapshot request, sampled only while idle
//   i_data              7 x BUS_SIZE data words (bus_a .. next_seq_pc)
//   i_fields, i_ctrl    instruction fields (27b) and control bits (19b)
//   o_byte/o_valid/i_ready/o_last  byte stream handshake
//   o_busy              high whenever a frame is in progress
//   o_done              one-cycle pulse after the final byte is accepted
module pipe_snapshot_reader #(
    parameter int BUS_SIZE = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req,
    input  logic [7*BUS_SIZE-1:0] i_data,
    input  logic [26:0]           i_fields,
    input  logic [18:0]           i_ctrl,
    input  logic                  i_ready,
    output logic [7:0]            o_byte,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int NB = 9 * BUS_SIZE / 8;
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);
`ifdef SNAP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CHECKSUM, DONE} state_t;
    logic [7:0] chk;
`else
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;
`endif
    state_t                state;
    logic [9*BUS_SIZE-1:0] snap;
    logic [CW-1:0]         idx;
    logic [CW-1:0]         nidx;
    assign nidx = idx + 1'b1;
    assign o_busy = state != IDLE;
    // Outputs are registered: each transfer loads the byte that will be presented next.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            snap    <= '0;
            idx     <= '0;
            o_byte  <= 8'h00;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_done  <= 1'b0;
`ifdef SNAP_CHECKSUM_EN
            chk     <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_req) begin
                        snap    <= {BUS_SIZE'(i_ctrl), BUS_SIZE'(i_fields), i_data};
                        idx     <= '0;
                        o_byte  <= 8'hA5;
                        o_valid <= 1'b1;
                        o_last  <= 1'b0;
                        state   <= HEADER;
`ifdef SNAP_CHECKSUM_EN
                        chk     <= 8'h00;
`endif
                    end
                end
                HEADER: if (i_ready) begin
                    o_byte <= snap[7:0];
                    idx    <= '0;
                    state  <= PAYLOAD;
`ifdef SNAP_CHECKSUM_EN
                    chk    <= o_byte;
`endif
                end
                PAYLOAD: if (i_ready) begin
                    if (idx == LAST) begin
`ifdef SNAP_CHECKSUM_EN
                        // Checksum byte folds in the payload byte being accepted right now.
                        o_byte <= chk ^ o_byte;
                        o_last <= 1'b1;
                        state  <= CHECKSUM;
`else
                        o_byte  <= 8'h00;
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        o_done  <= 1'b1;
                        state   <= DONE;
`endif
                    end else begin
                        idx    <= nidx;
                        o_byte <= snap[{nidx, 3'b000} +: 8];
`ifndef SNAP_CHECKSUM_EN
                        o_last <= nidx == LAST;
`endif
                    end
`ifdef SNAP_CHECKSUM_EN
                    chk <= chk ^ o_byte;
`endif
                end
`ifdef SNAP_CHECKSUM_EN
                CHECKSUM: if (i_ready) begin
                    o_byte  <= 8'h00;
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                    o_done  <= 1'b1;
                    state   <= DONE;
                end
`endif
                DONE: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_snapshot_reader.sv
// tb_pipe_snapshot_reader: directed self-checking bench for pipe_snapshot_reader
module tb_pipe_snapshot_reader;
    localparam int BS = 32;
`ifdef SNAP_CHECKSUM_EN
    localparam int N = 38;
`else
    localparam int N = 37;
`endif
    logic            clk = 1'b0;
    logic            reset, req, ready;
    logic [7*BS-1:0] data;
    logic [26:0]     fields;
    logic [18:0]     ctrl;
    logic [7:0]      obyte;
    logic            valid, last, busy, done;
    int              checks = 0;
    int              failures = 0;
    logic [7:0]      exp [0:37];
    logic [7:0]      got [0:37];
    int              ngot;
    int              cyc;

    always #5 clk = ~clk;

    pipe_snapshot_reader #(.BUS_SIZE(BS)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_data(data), .i_fields(fields),
        .i_ctrl(ctrl), .i_ready(ready), .o_byte(obyte), .o_valid(valid), .o_last(last),
        .o_busy(busy), .o_done(done)
    );

    task automatic build_exp;
        logic [9*BS-1:0] w;
        logic [7:0] x;
        w = {13'b0, ctrl, 5'b0, fields, data};
        exp[0] = 8'hA5;
        x = 8'hA5;
        for (int i = 0; i < 36; i++) begin
            exp[i+1] = w[i*8 +: 8];
            x ^= exp[i+1];
        end
        exp[37] = x;
    endtask

    task automatic start_frame(input string name);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0)
            begin failures++; $display("FAIL %s idle_before_req: busy=%b done=%b valid=%b want 0 0 0", name, busy, done, valid); end
        build_exp();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checks++;
        if (valid !== 1'b1 || obyte !== 8'hA5 || busy !== 1'b1)
            begin failures++; $display("FAIL %s header_latency: valid=%b byte=%h busy=%b want 1 a5 1", name, valid, obyte, busy); end
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating.
    task automatic run_frame(input string name, input int mode, input int poke_at, input int reset_at);
        logic stalled;
        logic poked;
        logic [7:0] pb;
        logic pl;
        stalled = 1'b0;
        poked = 1'b0;
        pb = 8'h00;
        pl = 1'b0;
        ngot = 0;
        cyc = 0;
        while (ngot < N && cyc < 400) begin
            req = 1'b0;
            ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (stalled) begin
                checks++;
                if (valid !== 1'b1 || obyte !== pb || last !== pl)
                    begin failures++; $display("FAIL %s stall_hold: valid=%b byte=%h last=%b want 1 %h %b", name, valid, obyte, last, pb, pl); end
            end
            if (ngot == reset_at) begin
                #2 reset = 1'b1;
                #1;
                checks++;
                if (obyte !== 8'h00 || valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
                    begin failures++; $display("FAIL %s async_reset: byte=%h valid=%b last=%b busy=%b done=%b want 00 0 0 0 0", name, obyte, valid, last, busy, done); end
                #1 reset = 1'b0;
                return;
            end
            if (ngot == poke_at && !poked) begin
                poked = 1'b1;
                req = 1'b1;
                data = data ^ {7{32'h5A5A_C3C3}};
                fields = ~fields;
                ctrl = ~ctrl;
            end
            stalled = valid && !ready;
            pb = obyte;
            pl = last;
            if (valid === 1'b1 && ready) begin
                checks++;
                if (last !== (ngot == N - 1))
                    begin failures++; $display("FAIL %s last_flag byte%0d: last=%b want %b", name, ngot, last, ngot == N - 1); end
                got[ngot] = obyte;
                ngot++;
            end else if (valid !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL %s valid_drop byte%0d: valid=%b want 1", name, ngot, valid);
            end
            @(negedge clk);
            cyc++;
        end
        req = 1'b0;
        checks++;
        if (ngot != N)
            begin failures++; $display("FAIL %s byte_count: got=%0d want %0d", name, ngot, N); end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1)
            begin failures++; $display("FAIL %s done_pulse: done=%b valid=%b busy=%b want 1 0 1", name, done, valid, busy); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== exp[i])
                begin failures++; $display("FAIL %s byte%0d: got=%h want %h", name, i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req = 1'b0;
        ready = 1'b0;
        data = '0;
        fields = '0;
        ctrl = '0;
        #3;
        checks++;
        if (obyte !== 8'h00 || valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin failures++; $display("FAIL reset_state: byte=%h valid=%b last=%b busy=%b done=%b want 00 0 0 0 0", obyte, valid, last, busy, done); end
        @(negedge clk);
        reset = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL ready_while_idle: valid=%b busy=%b want 0 0", valid, busy); end
    endtask

    task automatic test_basic;
        data = {32'h6666_0006, 32'h5555_0005, 32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'hDEAD_BEEF, 32'h1122_3344};
        fields = 27'h5AB_CDEF;
        ctrl = 19'h2_A5C3;
        start_frame("basic");
        run_frame("basic", 0, -1, -1);
        checks++;
        if (got[1] !== 8'h44 || got[2] !== 8'h33 || got[3] !== 8'h22 || got[4] !== 8'h11)
            begin failures++; $display("FAIL basic_word0: got=%h %h %h %h want 44 33 22 11", got[1], got[2], got[3], got[4]); end
        checks++;
        if (cyc != N)
            begin failures++; $display("FAIL basic_cycles: got=%0d want %0d", cyc, N); end
    endtask

    task automatic test_halt;
        data = '0;
        fields = '0;
        ctrl = 19'h4_0000;
        start_frame("halt");
        run_frame("halt", 0, -1, -1);
        checks++;
        if (got[33] !== 8'h00 || got[34] !== 8'h00 || got[35] !== 8'h04 || got[36] !== 8'h00)
            begin failures++; $display("FAIL halt_ctrl_bytes: got=%h %h %h %h want 00 00 04 00", got[33], got[34], got[35], got[36]); end
`ifdef SNAP_CHECKSUM_EN
        checks++;
        if (got[37] !== 8'hA1)
            begin failures++; $display("FAIL halt_checksum: got=%h want a1", got[37]); end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL halt_done_one_cycle: done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_stall;
        data = {32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4, 32'hD1D2_D3D4, 32'hE1E2_E3E4, 32'hF1F2_F3F4, 32'h0102_0304};
        fields = 27'h123_4567;
        ctrl = 19'h7_1234;
        start_frame("stall");
        run_frame("stall", 1, -1, -1);
    endtask

    task automatic test_ignore_req;
        data = {32'h0F0F_0F0F, 32'h7777_8888, 32'h1357_9BDF, 32'h2468_ACE0, 32'hCAFE_F00D, 32'h8000_0001, 32'h0BAD_F00D};
        fields = 27'h7FF_FFFF;
        ctrl = 19'h0_0001;
        start_frame("ignore_req");
        run_frame("ignore_req", 0, 11, -1);
    endtask

    task automatic test_reset_mid;
        data = {7{32'h9ABC_DEF0}};
        fields = 27'h0AA_AAAA;
        ctrl = 19'h5_5555;
        start_frame("reset_mid");
        run_frame("reset_mid", 0, -1, 21);
        data = {7{32'h1234_5678}};
        start_frame("after_reset");
        run_frame("after_reset", 0, -1, -1);
    endtask

    task automatic test_back_to_back;
        data = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        fields = 27'h000_0011;
        ctrl = 19'h0_0022;
        start_frame("b2b_first");
        run_frame("b2b_first", 0, -1, -1);
        data = {32'hFFFF_0000, 32'hEEEE_1111, 32'hDDDD_2222, 32'hCCCC_3333, 32'hBBBB_4444, 32'hAAAA_5555, 32'h9999_6666};
        fields = 27'h3C3_C3C3;
        ctrl = 19'h6_0F0F;
        start_frame("b2b_second");
        run_frame("b2b_second", 0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_halt();
        test_stall();
        test_ignore_req();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_snapshot_reader.md
PIPE_SNAPSHOT_READER -- requirements
Module: pipe_snapshot_reader

Interface
REQ-001 Parameter BUS_SIZE, default 32, is the data word width; SHALL be a multiple of 8; all byte counts below assume 32.
REQ-002 i_clk  in  1  clock; all state changes on rising edge.
REQ-003 i_reset  in  1  reset, asynchronous, active-high.
REQ-004 i_req  in  1  snapshot request; sampled only in IDLE.
REQ-005 i_data  in  7*BUS_SIZE  ID/EX data words; word k at [k*BUS_SIZE +: BUS_SIZE]: 0 bus_a, 1 bus_b, 2 inm_ext_signed, 3 inm_upp, 4 inm_ext_unsigned, 5 shamt_ext_unsigned, 6 next_seq_pc.
REQ-006 i_fields  in  27  rs[4:0], rt[9:5], rd[14:10], funct[20:15], op[26:21].
REQ-007 i_ctrl  in  19  jmp_stop[0], mem_rd_src[3:1], mem_wr_src[5:4], mem_write[6], wb[7], mem_to_reg[8], reg_dst[10:9], alu_src_a[11], alu_src_b[14:12], alu_op[17:15], halt[18].
REQ-008 o_byte  out  8  current stream byte.
REQ-009 o_valid  out  1  o_byte valid.
REQ-010 i_ready  in  1  sink accepts o_byte this cycle.
REQ-011 o_last  out  1  o_byte is final byte of frame.
REQ-012 o_busy  out  1  high in any state except IDLE.
REQ-013 o_done  out  1  one-cycle pulse after final byte accepted.

Function
REQ-014 States: IDLE, HEADER, PAYLOAD, CHECKSUM (macro only), DONE.
REQ-015 IDLE with i_req=1 at an edge: capture i_data/i_fields/i_ctrl into snapshot register, go HEADER; o_valid high the following cycle (1-cycle latency).
REQ-016 i_req ignored outside IDLE; inputs changing after capture do not alter the frame.
REQ-017 Transfer occurs on an edge with o_valid=1 and i_ready=1; o_valid/o_byte/o_last SHALL hold stable while o_valid=1 and i_ready=0.
REQ-018 HEADER: o_byte=0xA5; on transfer go PAYLOAD with byte index 0.
REQ-019 PAYLOAD: 36 bytes, index 0..35 (6-bit counter); word 7 = {5'b0, fields}, word 8 = {13'b0, ctrl}; words 0..8 in order, least-significant byte first.
REQ-020 Transfer of index 35: go CHECKSUM if macro defined, else DONE; counter SHALL NOT wrap to 0 within a frame.
REQ-021 o_valid=0 in IDLE and DONE; 1 in HEADER, PAYLOAD, CHECKSUM.
REQ-022 DONE lasts exactly one cycle with o_done=1, then IDLE; i_req during DONE is ignored.
REQ-023 i_ready asserted while o_valid=0 SHALL have no effect.
REQ-024 Back-to-back: with i_ready held high, frame occupies 1 (capture) + N transfer cycles + 1 DONE cycle; next i_req accepted in the following IDLE cycle.

Reset
REQ-025 i_reset asserted (any time, including mid-frame): state IDLE, counter 0, snapshot and checksum cleared, o_byte=0x00, o_valid=0, o_last=0, o_busy=0, o_done=0, immediately and without waiting for i_clk.
REQ-026 A frame interrupted by reset SHALL NOT resume; a new i_req restarts from HEADER.

Configuration
REQ-027 Macro SNAP_CHECKSUM_EN defined: after payload, CHECKSUM state emits one byte = XOR of 0xA5 and all 36 payload bytes; o_last=1 only on that byte; frame = 38 bytes.
REQ-028 SNAP_CHECKSUM_EN undefined: no CHECKSUM state or checksum logic; o_last=1 on payload index 35; frame = 37 bytes.

Verification
REQ-029 Reset, i_req=1 one cycle with word0=0x11223344, i_ready=1 -> o_byte sequence 0xA5, 0x44, 0x33, 0x22, 0x11, ...; o_valid rises cycle after request.
REQ-030 All inputs zero, i_ctrl[18]=1, i_ready=1 -> payload bytes 32..35 = 0x00, 0x00, 0x04, 0x00; with macro checksum byte = 0xA1; o_last on final byte only; o_done 1 cycle later.
REQ-031 i_ready toggling 1,0,0,1 repeating -> o_byte/o_valid stable through stalls; byte count 37/38 exact, no duplicates or drops.
REQ-032 i_req pulsed at payload index 10 and data changed after capture -> ignored; frame carries captured values.
REQ-033 i_reset asserted at payload index 20 between edges -> outputs zero immediately; subsequent i_req yields complete frame starting 0xA5.
REQ-034 Two requests, second asserted the cycle after o_done -> two complete frames, second captured from inputs at second request.
